// File: rtl/phase_sequencer.sv
// phase_sequencer
// Control-phase generator and instruction register for the non-pipelined CPU.
// It latches each instruction word from program RAM and steps through the
// one-hot phases FETCH/EXEC1/EXEC2/EXEC3. The decoder's extra/extra2 feedback
// sets the instruction length. A stop instruction parks the core in HALT, and
// only reset leaves that state.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   run          start/continue enable, sampled in IDLE and FETCH
//   ram_q        program RAM read data, valid during FETCH
//   extra        decoder feedback: instruction needs EXEC2 (sampled in EXEC1)
//   extra2       decoder feedback: instruction needs EXEC3 (sampled in EXEC2)
//   instr        instruction register, drives the decoder
//   fetch/exec1/exec2/exec3  phase strobes (Moore, at most one high)
//   halted       core stopped on a stop instruction
//   instr_count  number of instructions fetched (wraps silently)
module phase_sequencer #(
  parameter int unsigned IW = 16,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic [IW-1:0] ram_q,
  input  logic          extra,
  input  logic          extra2,
  output logic [IW-1:0] instr,
  output logic          fetch,
  output logic          exec1,
  output logic          exec2,
  output logic          exec3,
  output logic          halted,
  output logic [CW-1:0] instr_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC1 = 3'd2;
  localparam logic [2:0] S_EXEC2 = 3'd3;
  localparam logic [2:0] S_EXEC3 = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  localparam logic [4:0] STOP_OPCODE = 5'b11110;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       is_stop;
  logic       load;

  assign is_stop = (instr[15:11] == STOP_OPCODE);
  // Load and count only when FETCH goes on to EXEC1. When run drops, the
  // FETCH cycle still strobes, but the word is discarded.
  assign load    = (state == S_FETCH) && run;

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = run ? S_FETCH : S_IDLE;
      S_FETCH: state_nxt = run ? S_EXEC1 : S_IDLE;
      // Stop detection takes priority over the decoder's extra request.
      S_EXEC1: begin
        if (is_stop)    state_nxt = S_HALT;
        else if (extra) state_nxt = S_EXEC2;
        else            state_nxt = S_FETCH;
      end
      S_EXEC2: state_nxt = extra2 ? S_EXEC3 : S_FETCH;
      S_EXEC3: state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instr       <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        instr       <= ram_q;
        instr_count <= instr_count + 1'b1;
      end
    end
  end

  always_comb begin
    fetch  = 1'b0;
    exec1  = 1'b0;
    exec2  = 1'b0;
    exec3  = 1'b0;
    halted = 1'b0;
    case (state)
      S_FETCH: fetch  = 1'b1;
      S_EXEC1: exec1  = 1'b1;
      S_EXEC2: exec2  = 1'b1;
      S_EXEC3: exec3  = 1'b1;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule
